// File: rtl/ppt_pkg.sv
// ppt_pkg: shared types and helpers for the pulse-train burst sequencer.
//   state_t        burst FSM states (IDLE, ARM, RUN, STOP, DONE)
//   CNT_W_DEFAULT  default width of period/width/count fields
//   cfg_valid()    burst configuration check, also used by the register map
// Optional feature: PPT_BURST_CONTINUOUS_EN makes cfg_count==0 legal
// (continuous mode); otherwise a zero count is a configuration error.
package ppt_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    STOP,
    DONE
  } state_t;

  // Fields are passed zero-extended to 32 bits so that callers of any
  // width up to 32 can share one function.
  function automatic logic cfg_valid(input logic [31:0] period,
                                     input logic [31:0] width,
                                     input logic [31:0] count);
    logic ok;
    ok = (width != '0) && (width < period);
`ifdef PPT_BURST_CONTINUOUS_EN
    // A zero count selects continuous mode and is accepted.
    ok = ok;
`else
    ok = ok && (count != '0);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/ppt_burst_ctrl_if.sv
// ppt_burst_ctrl_if: control/status bundle between the register map
// (master) and the burst sequencer (slave).
//   start, abort                        burst request / termination
//   cfg_period, cfg_width, cfg_count    burst configuration
//   busy, done, err, aborted            status flags
//   pulses_done                         rising edges counted in the burst
interface ppt_burst_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_count;
  logic             busy;
  logic             done;
  logic             err;
  logic             aborted;
  logic [CNT_W-1:0] pulses_done;

  modport master (
    output start, abort, cfg_period, cfg_width, cfg_count,
    input  busy, done, err, aborted, pulses_done
  );

  modport slave (
    input  start, abort, cfg_period, cfg_width, cfg_count,
    output busy, done, err, aborted, pulses_done
  );
endinterface

// File: rtl/ppt_edge_det.sv
// ppt_edge_det: rising-edge detector on a clk-synchronous signal.
//   clk, rst  clock and asynchronous active-high reset
//   sig_i     input level
//   rise_o    high in the cycle where sig_i is 1 and was 0 the cycle before
module ppt_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/ppt_burst_ctrl.sv
// ppt_burst_ctrl: burst sequencer for the pulse generator.
//   clk, rst      divided clock, asynchronous active-high reset
//   pulse_in_i    generator pulse output
//   gen_run_o     generator enable
//   gen_period_o  shadowed period, gen_width_o shadowed width
//   ctl           control/status bundle (ppt_burst_ctrl_if.slave)
// Optional feature: PPT_BURST_CONTINUOUS_EN -- a zero pulse count runs
// until abort instead of being rejected.
module ppt_burst_ctrl
  import ppt_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in_i,
  output logic             gen_run_o,
  output logic [CNT_W-1:0] gen_period_o,
  output logic [CNT_W-1:0] gen_width_o,
  ppt_burst_ctrl_if.slave  ctl
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;
  logic             rise;
  logic             cfg_ok;
  logic [CNT_W-1:0] cnt_inc;
  logic             count_hit;

  ppt_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (pulse_in_i),
    .rise_o (rise)
  );

  assign cfg_ok  = cfg_valid(32'(ctl.cfg_period), 32'(ctl.cfg_width),
                             32'(ctl.cfg_count));
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Compare the post-increment value so the FSM leaves RUN on the same
  // edge that records the final rise.
`ifdef PPT_BURST_CONTINUOUS_EN
  assign count_hit = (count_q != '0) && (cnt_inc == count_q);
`else
  assign count_hit = (cnt_inc == count_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ctl.start) state_d = cfg_ok ? ARM : DONE;
      ARM:  state_d = ctl.abort ? DONE : RUN;
      RUN: begin
        if (ctl.abort)             state_d = DONE;
        else if (rise && count_hit) state_d = STOP;
      end
      // Hold run until the last pulse has finished its high time.
      STOP: if (ctl.abort || !pulse_in_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gen_run_o = (state_q == RUN) || (state_q == STOP);
    ctl.busy  = (state_q == ARM) || (state_q == RUN) || (state_q == STOP);
    ctl.done  = (state_q == DONE);
  end

  always_comb begin
    period_d  = period_q;
    width_d   = width_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (ctl.start) begin
          period_d  = ctl.cfg_period;
          width_d   = ctl.cfg_width;
          count_d   = ctl.cfg_count;
          cnt_d     = '0;
          err_d     = ~cfg_ok;
          aborted_d = 1'b0;
        end
      end
      ARM, STOP: if (ctl.abort) aborted_d = 1'b1;
      RUN: begin
        if (ctl.abort)  aborted_d = 1'b1;
        else if (rise)  cnt_d     = cnt_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q  <= '0;
      width_q   <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      width_q   <= width_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign gen_period_o    = period_q;
  assign gen_width_o     = width_q;
  assign ctl.pulses_done = cnt_q;
  assign ctl.err         = err_q;
  assign ctl.aborted     = aborted_q;

endmodule
